// File: rtl/delay_cascade_calibrator.sv
// ---------------------------------------------------------------------------
// delay_cascade_calibrator
//
// Purpose:
//   Closed-loop calibration controller for a programmable delay cascade.
//   It sweeps the thermometer select code upward from 0. For each code it
//   toggles the cascade input TRIALS times and checks that the delayed edge
//   reaches the sampling point every time. It reports the largest code that
//   always passed, which is the maximum safe delay setting for the current
//   PVT corner.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   start      in   1-cycle sweep request, honoured only in IDLE
//   dl_sample  in   cascade output captured at the sampling phase (clk domain)
//   dl_in      out  registered launch signal into the cascade
//   dl_sel     out  thermometer select to the cascade, (1<<code)-1
//   busy       out  high from the cycle after start is accepted through DONE
//   done       out  1-cycle pulse in the DONE state
//   cal_code   out  result code, held until the next done pulse
//   cal_err    out  code 0 failed; cal_code is forced to 0
// ---------------------------------------------------------------------------
module delay_cascade_calibrator #(
    parameter int NUM_STAGES = 6,
    parameter int SETTLE_CYC = 4,
    parameter int SAMPLE_DLY = 2,
    parameter int TRIAL_LOG2 = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              dl_sample,
    output logic                              dl_in,
    output logic [NUM_STAGES-1:0]             dl_sel,
    output logic                              busy,
    output logic                              done,
    output logic [$clog2(NUM_STAGES+1)-1:0]   cal_code,
    output logic                              cal_err
);

    localparam int TRIALS = 1 << TRIAL_LOG2;
    localparam int CODE_W = $clog2(NUM_STAGES + 1);
    localparam int CNT_W  = $clog2(((SETTLE_CYC > SAMPLE_DLY) ? SETTLE_CYC : SAMPLE_DLY) + 1);
    localparam int TRL_W  = TRIAL_LOG2 + 1;

    typedef enum logic [2:0] {
        IDLE, SETTLE, LAUNCH, WAIT, SAMPLE, EVAL, DONE
    } state_t;

    state_t              state, state_next;
    logic [CNT_W-1:0]    cnt;
    logic [TRL_W-1:0]    trial;
    logic [TRL_W-1:0]    hits;
    logic [CODE_W-1:0]   code;
    logic [CODE_W-1:0]   best;
    logic                err;
    logic                pass;
    logic                last_trial;
    logic                last_code;

    function automatic logic [NUM_STAGES-1:0] therm(input logic [CODE_W-1:0] c);
        logic [NUM_STAGES-1:0] t;
        for (int i = 0; i < NUM_STAGES; i++) begin
            t[i] = (i < int'(c));
        end
        return t;
    endfunction

    // No partial credit: every trial of a code must have hit.
    assign pass       = (hits == TRL_W'(TRIALS));
    assign last_trial = (trial == TRL_W'(TRIALS - 1));
    assign last_code  = (code == CODE_W'(NUM_STAGES));

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets its default before the case so no path leaves it
    // unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (start) state_next = SETTLE;
            SETTLE: if (cnt == CNT_W'(SETTLE_CYC - 1)) state_next = LAUNCH;
            LAUNCH: state_next = WAIT;
            WAIT:   if (cnt == CNT_W'(SAMPLE_DLY - 1)) state_next = SAMPLE;
            SAMPLE: state_next = last_trial ? EVAL : LAUNCH;
            // A failing code ends the sweep: delay is monotonic in code, so
            // higher codes cannot pass either.
            EVAL:   state_next = (pass && !last_code) ? SETTLE : DONE;
            DONE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            trial    <= '0;
            hits     <= '0;
            code     <= '0;
            best     <= '0;
            err      <= 1'b0;
            dl_in    <= 1'b0;
            dl_sel   <= '0;
            cal_code <= '0;
            cal_err  <= 1'b0;
        end else begin
            // One shared counter times both SETTLE and WAIT; it restarts on
            // every state change.
            if (state_next != state) begin
                cnt <= '0;
            end else if (state == SETTLE || state == WAIT) begin
                cnt <= cnt + 1'b1;
            end

            if (state_next == SETTLE && state != SETTLE) begin
                trial <= '0;
                hits  <= '0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        code   <= '0;
                        best   <= '0;
                        err    <= 1'b0;
                        dl_sel <= '0;
                    end
                end
                LAUNCH: dl_in <= ~dl_in;
                SAMPLE: begin
                    if (dl_sample == dl_in) hits <= hits + 1'b1;
                    if (!last_trial) trial <= trial + 1'b1;
                end
                EVAL: begin
                    if (pass) begin
                        best <= code;
                        if (!last_code) begin
                            code   <= code + 1'b1;
                            dl_sel <= therm(code + 1'b1);
                        end
                    end else if (code == '0) begin
                        err <= 1'b1;
                    end
                end
                DONE: begin
                    cal_code <= best;
                    cal_err  <= err;
                    dl_sel   <= therm(best);
                end
                default: ;
            endcase
        end
    end

endmodule
